// File: rtl/matmul_pkg.sv
// Definitions shared by the matrix-multiply blocks: drain sequencer states and the
// default result word width.
package matmul_pkg;

   localparam int DATA_W_DEF = 32;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_FLUSH = 2'd2,
      ST_DONE  = 2'd3
   } drain_state_e;

endpackage

// File: rtl/result_skid_fifo.sv
// Two-entry synchronous FIFO holding result words between the RAM read port and the
// output handshake; head_o is the oldest entry and count_o its occupancy.
module result_skid_fifo
   import matmul_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push_i,
   input  logic              pop_i,
   input  logic [DATA_W-1:0] push_data_i,
   output logic [DATA_W-1:0] head_o,
   output logic [1:0]        count_o
);

   logic [DATA_W-1:0] mem_q [2];
   logic              wr_ptr_q;
   logic              rd_ptr_q;
   logic [1:0]        count_q;
   logic              push_ok;
   logic              pop_ok;

   assign pop_ok  = pop_i && (count_q != 2'd0);
   // A full FIFO still takes a push when the head leaves in the same cycle.
   assign push_ok = push_i && ((count_q != 2'd2) || pop_ok);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int e = 0; e < 2; e++) begin
            mem_q[e] <= '0;
         end
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data_i;
         end
         wr_ptr_q <= wr_ptr_q ^ push_ok;
         rd_ptr_q <= rd_ptr_q ^ pop_ok;
         count_q  <= count_q + {1'b0, push_ok} - {1'b0, pop_ok};
      end
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

endmodule

// File: rtl/result_drain_ctrl.sv
// Drains the N x N result RAM in row-major order onto a valid/ready stream with
// row/col tags, a last-beat flag and a done pulse.
module result_drain_ctrl
   import matmul_pkg::*;
#(
   parameter int N      = 8,
   parameter int DATA_W = DATA_W_DEF,
   parameter int IDX_W  = $clog2(N),
   parameter int ADDR_W = $clog2(N*N)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_rd_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [IDX_W-1:0]  out_row,
   output logic [IDX_W-1:0]  out_col,
   output logic              out_last
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N*N-1);
   localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(N-1);

   drain_state_e      state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [IDX_W-1:0]  row_q, row_d;
   logic [IDX_W-1:0]  col_q, col_d;
   logic              inflight_q;

   logic [1:0]        fifo_count;
   logic [1:0]        occ_after;
   logic [DATA_W-1:0] fifo_head;
   logic              pop;
   logic              rd_issue;
   logic              last_beat;

   assign out_valid = (fifo_count != 2'd0);
   assign pop       = out_valid && out_ready;
   assign last_beat = (row_q == LAST_IDX) && (col_q == LAST_IDX);

   // Buffered words plus the read in flight, minus the word leaving now, must stay
   // below the FIFO depth for another read to be safe.
   assign occ_after = fifo_count + {1'b0, inflight_q} - {1'b0, pop};
   assign rd_issue  = (state_q == ST_READ) && (occ_after < 2'd2);

   result_skid_fifo #(
      .DATA_W (DATA_W)
   ) u_fifo (
      .clk         (clk),
      .rst_n       (rst_n),
      .push_i      (inflight_q),
      .pop_i       (pop),
      .push_data_i (mem_rd_data),
      .head_o      (fifo_head),
      .count_o     (fifo_count)
   );

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      row_d   = row_q;
      col_d   = col_q;

      if (pop) begin
         if (last_beat) begin
            row_d = '0;
            col_d = '0;
         end else if (col_q == LAST_IDX) begin
            row_d = row_q + IDX_W'(1);
            col_d = '0;
         end else begin
            col_d = col_q + IDX_W'(1);
         end
      end

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_READ;
               addr_d  = '0;
               row_d   = '0;
               col_d   = '0;
            end
         end
         ST_READ: begin
            if (rd_issue) begin
               addr_d = addr_q + ADDR_W'(1);
               if (addr_q == LAST_ADDR) begin
                  state_d = ST_FLUSH;
               end
            end
         end
         ST_FLUSH: begin
            if (pop && last_beat) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         addr_q     <= '0;
         row_q      <= '0;
         col_q      <= '0;
         inflight_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         row_q      <= row_d;
         col_q      <= col_d;
         inflight_q <= rd_issue;
      end
   end

   assign busy      = (state_q == ST_READ) || (state_q == ST_FLUSH);
   assign done      = (state_q == ST_DONE);
   assign mem_rd_en = rd_issue;
   assign mem_addr  = addr_q;
   assign out_data  = fifo_head;
   assign out_row   = row_q;
   assign out_col   = col_q;
   assign out_last  = out_valid && last_beat;

endmodule
